fetch_stage: RTL and testbench

Instruction-fetch stage of the 3-stage RISC-V core, directly upstream of decode/execution. Owns the program counter, drives a synchronous-read instruction ROM, and presents a registered IF/ID instruction word plus its address to decode. Applies redirects (`jump_en`/`jump_addr`) and stalls (`hold_en`) from ctrl, drops wrong-path fetches as NOPs, and keeps one ROM word in a skid buffer across a stall.

---
 rtl/fetch_stage_pkg.sv | 13 +
 rtl/fetch_stage_if.sv | 24 ++
 rtl/if_id_reg.sv | 55 +++++
 rtl/fetch_stage.sv | 106 ++++++++++
 tb/tb_fetch_stage.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage: the NOP bubble word,
// the reset fetch address and the word-alignment helper.
package fetch_stage_pkg;

    localparam logic [31:0] INST_NOP   = 32'h0000_0013;
    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
    localparam logic [31:0] INST_STEP  = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle between the fetch stage and its surroundings: ctrl redirect/stall,
// the instruction ROM port and the IF/ID outputs toward decode.
interface fetch_stage_if;

    logic        jump_en;
    logic [31:0] jump_addr;
    logic        hold_en;
    logic [31:0] rom_addr;
    logic [31:0] rom_rdata;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;

    modport master (
        input  jump_en, jump_addr, hold_en, rom_rdata,
        output rom_addr, inst_o, inst_addr_o, inst_valid_o
    );

    modport slave (
        output jump_en, jump_addr, hold_en, rom_rdata,
        input  rom_addr, inst_o, inst_addr_o, inst_valid_o
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a new word when enabled, and a bubble or
// reset forces the NOP word with valid cleared.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INST = INST_NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic        bubble,
    input  logic [31:0] inst_i,
    input  logic [31:0] addr_i,
    input  logic        valid_i,
    output logic [31:0] inst_o,
    output logic [31:0] addr_o,
    output logic        valid_o
);

    logic [31:0] inst_q, inst_d;
    logic [31:0] addr_q, addr_d;
    logic        valid_q, valid_d;

    always_comb begin
        inst_d  = inst_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        if (bubble) begin
            inst_d  = NOP_INST;
            addr_d  = 32'h0;
            valid_d = 1'b0;
        end else if (load_en) begin
            inst_d  = inst_i;
            addr_d  = addr_i;
            valid_d = valid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q  <= NOP_INST;
            addr_q  <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            inst_q  <= inst_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
        end
    end

    assign inst_o  = inst_q;
    assign addr_o  = addr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous ROM, tags the
// word in flight and parks it in a one-entry skid buffer across a stall.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_ADDR,
    parameter logic [31:0] NOP_INST = INST_NOP
) (
    input logic          clk,
    input logic          rst,
    fetch_stage_if.master bus
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        fetch_vld_q, fetch_vld_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        skid_vld_q, skid_vld_d;

    logic [31:0] jump_target;
    logic        load_en;
    logic [31:0] next_inst;
    logic [31:0] next_addr;
    logic        next_valid;

    assign jump_target  = align_word(bus.jump_addr);
    assign bus.rom_addr = rst ? RESET_PC : (bus.jump_en ? jump_target : pc_q);

    // rom_rdata only ever reaches flops, never an output directly.
    always_comb begin
        pc_d        = pc_q;
        fetch_pc_d  = fetch_pc_q;
        fetch_vld_d = fetch_vld_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        skid_vld_d  = skid_vld_q;
        load_en     = 1'b0;
        next_inst   = NOP_INST;
        next_addr   = 32'h0;
        next_valid  = 1'b0;

        if (bus.jump_en) begin
            pc_d        = jump_target + INST_STEP;
            fetch_pc_d  = jump_target;
            fetch_vld_d = 1'b1;
            skid_vld_d  = 1'b0;
        end else if (bus.hold_en) begin
            if (fetch_vld_q) begin
                skid_inst_d = bus.rom_rdata;
                skid_pc_d   = fetch_pc_q;
                skid_vld_d  = 1'b1;
            end
            fetch_vld_d = 1'b0;
        end else begin
            pc_d        = pc_q + INST_STEP;
            fetch_pc_d  = pc_q;
            fetch_vld_d = 1'b1;
            skid_vld_d  = 1'b0;
            load_en     = 1'b1;
            if (skid_vld_q) begin
                next_inst  = skid_inst_q;
                next_addr  = skid_pc_q;
                next_valid = 1'b1;
            end else if (fetch_vld_q) begin
                next_inst  = bus.rom_rdata;
                next_addr  = fetch_pc_q;
                next_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            fetch_pc_q  <= 32'h0;
            fetch_vld_q <= 1'b0;
            skid_inst_q <= NOP_INST;
            skid_pc_q   <= 32'h0;
            skid_vld_q  <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            fetch_pc_q  <= fetch_pc_d;
            fetch_vld_q <= fetch_vld_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
            skid_vld_q  <= skid_vld_d;
        end
    end

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .load_en (load_en),
        .bubble  (bus.jump_en),
        .inst_i  (next_inst),
        .addr_i  (next_addr),
        .valid_i (next_valid),
        .inst_o  (bus.inst_o),
        .addr_o  (bus.inst_addr_o),
        .valid_o (bus.inst_valid_o)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a directed vector table, hand sequences for stall
// corners and wraparound, then random traffic against a queue-based model.
module tb_fetch_stage;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] RST_A = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000 + {2'b00, a[31:2]};
    endfunction

    always @(posedge clk) bus.rom_rdata <= rom_word(bus.rom_addr);

    always @(negedge clk) begin
        total++;
        assert (!(dut.fetch_vld_q && dut.skid_vld_q)) else begin
            bad++;
            $display("[TB] FAIL vld_invariant: fetch_vld=%b skid_vld=%b, required not both 1",
                     dut.fetch_vld_q, dut.skid_vld_q);
        end
    end

    // Reference: the stage delivers addresses in order; at most one issued
    // address is owed to decode, and a stall simply keeps owing it.
    logic [31:0] m_pc = RST_A;
    logic [31:0] m_pend[$];
    logic [31:0] m_inst = NOP;
    logic [31:0] m_addr = 32'h0;
    logic        m_valid = 1'b0;
    logic [31:0] obs_rom;

    task automatic model_step(input logic r, j, h, input logic [31:0] ja);
        logic [31:0] a;
        if (r) begin
            m_pc = RST_A;
            m_pend.delete();
            m_inst = NOP; m_addr = 32'h0; m_valid = 1'b0;
        end else if (j) begin
            a = {ja[31:2], 2'b00};
            m_pend.delete();
            m_pend.push_back(a);
            m_pc = a + 32'd4;
            m_inst = NOP; m_addr = 32'h0; m_valid = 1'b0;
        end else if (!h) begin
            if (m_pend.size() > 0) begin
                a = m_pend.pop_front();
                m_inst = rom_word(a); m_addr = a; m_valid = 1'b1;
            end else begin
                m_inst = NOP; m_addr = 32'h0; m_valid = 1'b0;
            end
            m_pend.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic apply_stimulus(input logic r, j, h, input logic [31:0] ja);
        logic [31:0] exp_rom;
        rst = r;
        bus.jump_en = j;
        bus.hold_en = h;
        bus.jump_addr = ja;
        #1;
        exp_rom = r ? RST_A : (j ? {ja[31:2], 2'b00} : m_pc);
        obs_rom = bus.rom_addr;
        check_output("model_rom_addr", obs_rom, exp_rom);
        model_step(r, j, h, ja);
        @(posedge clk);
        #1;
        check_output("model_inst", bus.inst_o, m_inst);
        check_output("model_inst_addr", bus.inst_addr_o, m_addr);
        check_output("model_valid", {31'h0, bus.inst_valid_o}, {31'h0, m_valid});
    endtask

    typedef struct {
        logic        rst, jump, hold;
        logic [31:0] jaddr;
        logic [31:0] exp_rom, exp_inst, exp_addr;
        logic        exp_valid;
    } vec_t;

    function automatic vec_t mk(input logic r, j, h, input logic [31:0] ja, rom, inst, addr,
                                input logic v);
        vec_t t;
        t.rst = r; t.jump = j; t.hold = h; t.jaddr = ja;
        t.exp_rom = rom; t.exp_inst = inst; t.exp_addr = addr; t.exp_valid = v;
        return t;
    endfunction

    vec_t vecs[21];

    task automatic check_regs(input string tag, input logic [31:0] inst, addr, input logic v);
        check_output({tag, "_inst"}, bus.inst_o, inst);
        check_output({tag, "_addr"}, bus.inst_addr_o, addr);
        check_output({tag, "_valid"}, {31'h0, bus.inst_valid_o}, {31'h0, v});
    endtask

    initial begin
        bus.jump_en = 1'b0;
        bus.hold_en = 1'b0;
        bus.jump_addr = 32'h0;

        // Each entry: inputs for cycle k, rom_addr in cycle k, outputs in cycle k+1.
        vecs[0] = mk(0, 0, 0, 32'h0, 32'h0, NOP, 32'h0, 0);
        for (int k = 1; k < 10; k++)
            vecs[k] = mk(0, 0, 0, 32'h0, 32'(4 * k), 32'h1000 + 32'(k - 1), 32'(4 * (k - 1)), 1);
        vecs[10] = mk(0, 1, 0, 32'h86, 32'h84, NOP,       32'h0,  0);
        vecs[11] = mk(0, 0, 0, 32'h0,  32'h88, 32'h1021, 32'h84, 1);
        vecs[12] = mk(0, 0, 0, 32'h0,  32'h8C, 32'h1022, 32'h88, 1);
        vecs[13] = mk(0, 0, 1, 32'h0,  32'h90, 32'h1022, 32'h88, 1);
        vecs[14] = mk(0, 0, 1, 32'h0,  32'h90, 32'h1022, 32'h88, 1);
        vecs[15] = mk(0, 0, 1, 32'h0,  32'h90, 32'h1022, 32'h88, 1);
        vecs[16] = mk(0, 0, 0, 32'h0,  32'h90, 32'h1023, 32'h8C, 1);
        vecs[17] = mk(0, 0, 1, 32'h0,  32'h94, 32'h1023, 32'h8C, 1);
        vecs[18] = mk(0, 1, 1, 32'h20, 32'h20, NOP,       32'h0,  0);
        vecs[19] = mk(0, 0, 0, 32'h0,  32'h24, 32'h1008, 32'h20, 1);
        vecs[20] = mk(0, 0, 0, 32'h0,  32'h28, 32'h1009, 32'h24, 1);

        $display("[TB] reset and directed table");
        apply_stimulus(1, 0, 0, 32'h0);
        apply_stimulus(1, 0, 0, 32'h0);
        check_regs("reset", NOP, 32'h0, 0);
        for (int i = 0; i < 21; i++) begin
            apply_stimulus(vecs[i].rst, vecs[i].jump, vecs[i].hold, vecs[i].jaddr);
            check_output($sformatf("vec%0d_rom_addr", i), obs_rom, vecs[i].exp_rom);
            check_regs($sformatf("vec%0d", i), vecs[i].exp_inst, vecs[i].exp_addr, vecs[i].exp_valid);
        end

        $display("[TB] hold during fill");
        apply_stimulus(1, 0, 0, 32'h0);
        apply_stimulus(0, 0, 1, 32'h0);
        check_regs("fill_hold0", NOP, 32'h0, 0);
        apply_stimulus(0, 0, 1, 32'h0);
        check_regs("fill_hold1", NOP, 32'h0, 0);
        apply_stimulus(0, 0, 0, 32'h0);
        check_output("fill_release_rom_addr", obs_rom, RST_A);
        check_regs("fill_release", NOP, 32'h0, 0);
        apply_stimulus(0, 0, 0, 32'h0);
        check_regs("fill_first", 32'h1000, RST_A, 1);

        $display("[TB] pc wraparound and reset during hold");
        apply_stimulus(0, 1, 0, 32'hFFFF_FFF8);
        check_regs("wrap_jump", NOP, 32'h0, 0);
        apply_stimulus(0, 0, 0, 32'h0);
        check_output("wrap_rom_fffc", obs_rom, 32'hFFFF_FFFC);
        check_regs("wrap_fff8", 32'h4000_0FFE, 32'hFFFF_FFF8, 1);
        apply_stimulus(0, 0, 0, 32'h0);
        check_output("wrap_rom_0", obs_rom, 32'h0);
        check_regs("wrap_fffc", 32'h4000_0FFF, 32'hFFFF_FFFC, 1);
        apply_stimulus(0, 0, 0, 32'h0);
        check_regs("wrap_0", 32'h1000, 32'h0, 1);
        apply_stimulus(0, 0, 1, 32'h0);
        apply_stimulus(1, 0, 1, 32'h0);
        check_regs("hold_rst", NOP, 32'h0, 0);
        apply_stimulus(0, 0, 0, 32'h0);
        check_regs("hold_rst_c1", NOP, 32'h0, 0);
        apply_stimulus(0, 0, 0, 32'h0);
        check_regs("hold_rst_c2", 32'h1000, 32'h0, 1);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            logic        r, j, h;
            logic [31:0] ja;
            r  = ($urandom_range(0, 49) == 0);
            j  = ($urandom_range(0, 7) == 0);
            h  = ($urandom_range(0, 3) == 0);
            ja = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : 32'($urandom());
            apply_stimulus(r, j, h, ja);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
